// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO between the core's UART store path and the UART
//                transmitter. Accepts one byte per cycle from the core and
//                drains bytes into the transmitter through its send/busy
//                handshake, with a timeout on the busy acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    // core write port
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    // transmitter drain port
    output logic [7:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic                       ack_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;

    // Last counter value seen in ACK before the timeout fires; the increment
    // out of this value is the one that reaches ACK_TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             ack_err_q, ack_err_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    state_t           state_q,  state_d;

    // Strobes produced by the drain FSM and the write-accept decode
    logic push;
    logic pop;
    logic load;

    // ------------------------------------------------------------------
    // Status decode from the registered occupancy
    // ------------------------------------------------------------------
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign tx_data  = tx_data_q;
    assign ack_err  = ack_err_q;
    assign tx_send  = (state_q == S_SEND);

    // A write is only accepted against the registered full flag, so a pop in
    // the same cycle never frees space for it.
    assign push = wr_en && !full;

    // Drain FSM next-state logic: walks IDLE -> SEND -> ACK -> DONE -> IDLE.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        ack_err_d = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d = S_SEND;
                    load    = 1'b1;
                end
            end
            S_SEND: begin
                // Head entry leaves the FIFO as the pulse ends; the timeout
                // counter starts from zero on the first ACK cycle.
                pop     = 1'b1;
                tmo_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        // Transmitter never acknowledged; the byte is lost.
                        state_d   = S_IDLE;
                        ack_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next-state: pointers, occupancy, overflow flag, output byte.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        tx_data_d = tx_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A dropped write outranks a simultaneous clear.
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        // The presented byte is captured as SEND is entered and held until
        // the next transfer starts.
        if (load) begin
            tx_data_d = mem_q[rd_ptr_q];
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_data_q <= 8'h00;
            ack_err_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_data_q <= tx_data_d;
            ack_err_q <= ack_err_d;
            tmo_q     <= tmo_d;
        end
    end

    // Buffer array write; contents are meaningless until covered by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo with a small
//                transmitter model and an in-order byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 64;
    localparam int CNT_W       = 5;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             wr_en   = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             clr_ovf = 1'b0;
    logic             tx_busy = 1'b0;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       tx_data;
    logic             tx_send;
    logic             ack_err;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_send = -100;
    logic [7:0] exp_q[$];

    // Transmitter model controls
    bit bfm_hold    = 1'b0;
    bit bfm_respond = 1'b1;
    int bfm_len     = 2;
    int bcnt        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit acc);
        wr_en   = 1'b1;
        wr_data = d;
        if (acc) exp_q.push_back(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_send(input string name, input int budget);
        int n = 0;
        while (!tx_send && n < budget) begin
            step();
            n++;
        end
        chk(name, tx_send, 1'b1);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (!empty && n < budget) begin
            step();
            n++;
        end
        chk(name, empty, 1'b1);
        repeat (16) step();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for bfm_len cycles starting in the send cycle.
    always begin
        @(posedge clk);
        #2;
        if (tx_send && bfm_respond) bcnt = bfm_len;
        tx_busy = bfm_hold || (bcnt > 0);
        if (bcnt > 0) bcnt--;
    end

    // Output monitor: send order, pulse spacing, occupancy bound.
    always begin
        @(posedge clk);
        #1;
        if (!rst) chk("count_le_depth", (count <= CNT_W'(DEPTH)), 1'b1);
        if (tx_send) begin
            chk("send_gap", ((cyc - last_send) >= 3), 1'b1);
            last_send = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_send: got tx_data 0x%0h, want no send", tx_data);
            end else begin
                chk("tx_data_order", tx_data, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         clr;
        bit         acc;
        logic [4:0] cnt;
        bit         fu;
        bit         em;
        bit         ov;
    } vec_t;

    vec_t vt[21];

    initial begin
        // Fill/overflow table, transmitter held busy so nothing drains.
        vt[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 16; i++)
            vt[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 5'(i), (i == 16), 1'b0, 1'b0};
        vt[17] = '{1'b1, 8'h99, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
        vt[19] = '{1'b1, 8'h9A, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_ack_err", ack_err, 0);
        rst = 1'b0;
        step();

        // ---------------- three bytes, busy 10 per byte ----------------
        bfm_hold = 1'b1;
        step();
        wr(8'h41, 1);
        wr(8'h42, 1);
        wr(8'h43, 1);
        chk("t1_count_loaded", count, 3);
        bfm_len  = 10;
        bfm_hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_send("t1_send_seen", 200);
            chk("t1_count_at_send", count, 3 - k);
            step();
        end
        wait_empty("t1_drained", 200);
        chk("t1_count_end", count, 0);
        chk("t1_empty_end", empty, 1);

        // ---------------- fill / overflow table ----------------
        bfm_len  = 2;
        bfm_hold = 1'b1;
        step();
        for (int i = 0; i < 21; i++) begin
            wr_en   = vt[i].wr;
            wr_data = vt[i].d;
            clr_ovf = vt[i].clr;
            if (vt[i].wr && vt[i].acc) exp_q.push_back(vt[i].d);
            step();
            chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d_full", i), full, vt[i].fu);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].em);
            chk($sformatf("vec%0d_overflow", i), overflow, vt[i].ov);
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;

        // ---------------- write while full with simultaneous pop ----------------
        bfm_hold = 1'b0;
        wait_send("fp_send", 20);
        chk("fp_full_at_send", full, 1);
        wr(8'hEE, 0);
        chk("fp_count", count, 15);
        chk("fp_overflow", overflow, 1);
        chk("fp_full_after", full, 0);
        wait_empty("fp_drained", 400);
        chk("fp_overflow_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("fp_overflow_cleared", overflow, 0);

        // ---------------- push and pop together at count 5 ----------------
        bfm_hold = 1'b1;
        step();
        for (int i = 0; i < 5; i++) wr(8'(8'h61 + i), 1);
        chk("c5_count_loaded", count, 5);
        bfm_hold = 1'b0;
        wait_send("c5_send", 20);
        chk("c5_count_at_send", count, 5);
        wr(8'h77, 1);
        chk("c5_count_after", count, 5);
        wait_empty("c5_drained", 200);

        // ---------------- first-send latency from empty ----------------
        wr(8'h3C, 1);
        chk("lat_send_n1", tx_send, 0);
        chk("lat_count_n1", count, 1);
        chk("lat_empty_n1", empty, 0);
        step();
        chk("lat_send_n2", tx_send, 1);
        wait_empty("lat_drained", 100);

        // ---------------- acknowledge timeout ----------------
        bfm_respond = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        exp_q.push_back(8'h55);
        step();
        wr_data = 8'h66;
        exp_q.push_back(8'h66);
        chk("to_send_r1", tx_send, 0);
        step();
        wr_en = 1'b0;
        for (int r = 2; r <= 140; r++) begin
            chk($sformatf("to_send_r%0d", r), tx_send, (r == 2 || r == 68));
            chk($sformatf("to_ackerr_r%0d", r), ack_err, (r == 67 || r == 133));
            step();
        end
        bfm_respond = 1'b1;
        chk("to_empty", empty, 1);
        repeat (4) step();

        // ---------------- 40 bytes in bursts, pointers wrap ----------------
        bfm_len = 2;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) wr(8'((b * 10 + i) * 7 + 3), 1);
            wait_empty("wrap_drained", 300);
        end
        chk("wrap_scoreboard_empty", exp_q.size(), 0);

        // ---------------- reset while in DONE with 4 queued ----------------
        bfm_hold = 1'b1;
        step();
        for (int i = 0; i < 5; i++) wr(8'(8'hC1 + i), 1);
        bfm_len  = 10;
        bfm_hold = 1'b0;
        wait_send("rs_send", 20);
        step();
        step();
        chk("rs_count_in_done", count, 4);
        rst = 1'b1;
        step();
        chk("rs_count", count, 0);
        chk("rs_tx_send", tx_send, 0);
        chk("rs_tx_data", tx_data, 8'h00);
        chk("rs_empty", empty, 1);
        chk("rs_full", full, 0);
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk("rs_no_send", tx_send, 0);
            step();
        end

        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, want completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer between the core's UART store path and the UART transmitter. It accepts bytes from the core at core speed (one per cycle), holds up to DEPTH bytes, and drains them one at a time into the transmitter using its send/busy handshake. The core therefore no longer stalls on `tx_busy` for every byte. It sits directly upstream of the UART core. The core drives its write port; its drain port drives the transmitter's `tx_send` and `uart_io_thr` inputs.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; power of two, at least 2.
- `ACK_TIMEOUT`, 64: cycles to wait for `tx_busy` to rise after a send pulse before abandoning the handshake.

Ports:
- `clk`, in, 1: single clock for all logic; the transmitter's `tx_busy` is synchronous to it.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: write strobe from the core.
- `wr_data`, in, 8: byte to enqueue.
- `full`, out, 1: high when count equals DEPTH.
- `empty`, out, 1: high when count is 0.
- `count`, out, $clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky flag; set by a write attempted while full.
- `clr_ovf`, in, 1: clears `overflow`.
- `tx_data`, out, 8: byte presented to the transmitter.
- `tx_send`, out, 1: one-cycle send pulse to the transmitter.
- `tx_busy`, in, 1: transmitter busy.
- `ack_err`, out, 1: one-cycle pulse when `ACK_TIMEOUT` expires.

## Operation
Storage:
- Circular buffer of DEPTH x 8 bits, addressed by read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
- `count` is a registered counter.

Writes:
- A write is accepted when `wr_en` is high and `full` is low. It stores `wr_data` at the write pointer, increments the write pointer, and increments `count`.
- `wr_en` while `full` is high drops the byte and sets `overflow`.
- `full` and `empty` are decoded from the registered `count`. A pop in the same cycle does not make room for a write while `full` is high; that write is rejected.
- Push and pop in the same cycle when not full leaves `count` unchanged.
- When `clr_ovf` and an overflowing write occur in the same cycle, the set wins.

Drain state machine, Moore outputs:
- IDLE: when `count` is not 0 and `tx_busy` is low, go to SEND.
- SEND: `tx_send` is 1. `tx_data` is loaded from the head entry at entry to SEND and held through DONE. The entry is popped at the end of this cycle (read pointer increments, `count` decrements). Go to ACK.
- ACK: wait for `tx_busy` to be 1, then go to DONE. A timeout counter counts cycles spent in ACK. When it reaches `ACK_TIMEOUT`, pulse `ack_err` and go to IDLE; the byte is considered lost. Counter width is $clog2(ACK_TIMEOUT)+1, and it clears on entry to ACK.
- DONE: wait for `tx_busy` to be 0, then go to IDLE. DONE has no timeout.
- `tx_send` is never high in two consecutive cycles. At least 3 cycles separate successive send pulses.

## Timing
Reset:
- All state clears on `rst`: `count`=0, `empty`=1, `full`=0, `overflow`=0, `tx_send`=0, `tx_data`=0x00, `ack_err`=0, state IDLE, both pointers 0.
- Reset mid-transfer discards buffered bytes and drops `tx_send` in the next cycle. A byte already handed to the transmitter is unaffected.

Latency:
- Write accepted at edge N: `count`/`empty` reflect it from cycle N+1.
- From an empty FIFO with the transmitter idle, `tx_send` asserts in cycle N+2.
- Pop from SEND: `count` decrements in the cycle after SEND.

Write rate and status flags:
- Throughput on the write side is one byte per cycle until `full`.
- `overflow` and `ack_err` are registered and change one cycle after their cause.

## Test plan
- Write 0x41, 0x42, 0x43 back-to-back with the BFM transmitter busy for 10 cycles per byte -> three `tx_send` pulses carrying 0x41, 0x42, 0x43 in order; `count` goes 3,2,1,0; `empty`=1 at the end.
- Fill 16 bytes with the transmitter held busy, then write 0x99 -> `full`=1, `overflow`=1, 0x99 never appears on `tx_data`; `clr_ovf` -> `overflow`=0.
- Write 40 bytes in bursts so the pointers wrap twice -> the output sequence matches the input; `count` never exceeds 16.
- Transmitter never raises `tx_busy` after a send -> `ack_err` pulses exactly `ACK_TIMEOUT`+1 cycles after the SEND cycle; the next byte is sent afterwards.
- Simultaneous write and pop at `count`=5 -> `count` stays 5; while `full`=1 with a pop in the same cycle -> the write is rejected and `overflow` is set.
- Assert `rst` while in DONE with 4 bytes queued -> next cycle `count`=0, `tx_send`=0, `tx_data`=0x00, state IDLE; no further pulses occur.
